// File: rtl/shifter_right_seq.sv
// shifter_right_seq: 32-bit SRL/SRA right shifter, one log barrel stage per clock
module shifter_right_seq #(
  parameter logic [5:0] SRL = 6'b000010,
  parameter logic [5:0] SRA = 6'b000011
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [31:0] work;
  logic [4:0]  amt;
  logic        arith;
  logic [2:0]  stage;
  logic        accept;
  logic [32:0] ext;
  logic [32:0] sh;
  logic [31:0] shifted;
  always_comb begin
    accept  = (state != SHIFT) && start && (funct == SRL || funct == SRA);
    ext     = {arith & work[31], work};
    sh      = 33'($signed(ext) >>> (5'd1 << stage));
    shifted = amt[stage] ? sh[31:0] : work;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      dataOut <= '0;
      work    <= '0;
      amt     <= '0;
      arith   <= 1'b0;
      stage   <= '0;
    end else if (accept) begin
      work  <= dataA;
      amt   <= dataB[4:0];
      arith <= funct == SRA;
      stage <= '0;
      state <= SHIFT;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (state == SHIFT) begin
      work  <= shifted;
      stage <= stage + 3'd1;
      if (stage == 3'd4) begin
        dataOut <= shifted;
        state   <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shifter_right_seq.sv
// tb_shifter_right_seq: table, random and handshake checks with a result scoreboard
module tb_shifter_right_seq;
  localparam logic [5:0] SRL = 6'b000010, SRA = 6'b000011;
  logic clk = 0, reset_n = 0, start = 0, busy, done;
  logic [5:0] funct = SRL;
  logic [31:0] dataA = 0, dataB = 0, dataOut;
  int nVec = 0, nErr = 0;
  logic [31:0] q[$];
  typedef struct {logic [5:0] f; logic [31:0] a, b, e;} vec_t;
  vec_t vecs[10];

  shifter_right_seq dut (.clk(clk), .reset_n(reset_n), .start(start), .funct(funct),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done), .dataOut(dataOut));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n && done) begin
      if (q.size() == 0) begin
        nVec++;
        nErr++;
        $display("FAIL unexpected_done: got dataOut %h with no result expected", dataOut);
      end else chk("result", dataOut, q.pop_front());
    end

  task automatic waitDone(output int cyc, output int bc);
    cyc = 0;
    bc = 0;
    do begin
      @(negedge clk);
      start = 0;
      dataA = $urandom;
      dataB = $urandom;
      cyc++;
      bc += int'(busy);
    end while (!done && cyc < 20);
    chk("done_seen", done, 1);
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, b, e);
    funct = f;
    dataA = a;
    dataB = b;
    start = 1;
    q.push_back(e);
  endtask

  task automatic run(input logic [5:0] f, input logic [31:0] a, b, e);
    int cyc, bc;
    issue(f, a, b, e);
    waitDone(cyc, bc);
    chk("latency", cyc, 6);
    chk("busy_cycles", bc, 5);
    @(negedge clk);
    chk("done_width", done, 0);
  endtask

  initial begin
    int cyc, bc, seen;
    logic [31:0] a, b, e, held;
    logic [5:0] f;
    vecs[0] = '{SRL, 32'h80000000, 32'd31, 32'h00000001};
    vecs[1] = '{SRA, 32'h80000000, 32'd4, 32'hF8000000};
    vecs[2] = '{SRA, 32'h7FFFFFF0, 32'd4, 32'h07FFFFFF};
    vecs[3] = '{SRA, 32'hFFFFFFFF, 32'd31, 32'hFFFFFFFF};
    vecs[4] = '{SRL, 32'h12345678, 32'h00000024, 32'h01234567};
    vecs[5] = '{SRL, 32'h12345678, 32'hFFFFFFE0, 32'h12345678};
    vecs[6] = '{SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF};
    vecs[7] = '{SRL, 32'hF0000000, 32'd1, 32'h78000000};
    vecs[8] = '{SRA, 32'hF0000000, 32'd1, 32'hF8000000};
    vecs[9] = '{SRA, 32'h40000000, 32'd30, 32'h00000001};
    // reset dominates a pending start
    start = 1;
    funct = SRL;
    dataA = 32'hDEADBEEF;
    dataB = 32'd3;
    repeat (2) @(negedge clk);
    chk("rst_dataOut", dataOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    start = 0;
    reset_n = 1;
    @(negedge clk);
    chk("idle_after_rst", busy, 0);
    foreach (vecs[i]) run(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].e);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      f = $urandom_range(0, 1) ? SRA : SRL;
      e = (f == SRA) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      run(f, a, b, e);
    end
    // start re-pulsed mid-shift must be ignored
    issue(SRL, 32'h12345678, 32'd8, 32'h00123456);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    issue(SRA, 32'h80000000, 32'd1, 32'hC0000000);
    void'(q.pop_back());
    waitDone(cyc, bc);
    chk("restart_latency", cyc, 4);
    @(negedge clk);
    chk("restart_no_rerun", busy, 0);
    // back-to-back: accept in the DONE cycle
    issue(SRA, 32'h87654321, 32'd8, 32'hFF876543);
    waitDone(cyc, bc);
    issue(SRL, 32'h87654321, 32'd16, 32'h00008765);
    waitDone(cyc, bc);
    chk("b2b_spacing", cyc, 6);
    chk("b2b_busy", bc, 5);
    @(negedge clk);
    chk("b2b_done_width", done, 0);
    // abort at E3
    funct = SRL;
    dataA = 32'hFFFF0000;
    dataB = 32'd4;
    start = 1;
    repeat (3) begin
      @(negedge clk);
      start = 0;
    end
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dataOut", dataOut, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen += int'(done);
    end
    chk("abort_no_done", seen, 0);
    // illegal function code
    run(SRL, 32'hA5A5A5A5, 32'd2, 32'h29696969);
    held = 32'h29696969;
    issue(6'b000000, 32'h11111111, 32'd1, 32'h0);
    void'(q.pop_back());
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      start = 0;
      seen += int'(busy) + int'(done);
    end
    chk("illegal_idle", seen, 0);
    chk("illegal_dataOut", dataOut, held);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
